// File: rtl/alu_cmd_sequencer.sv
// Byte-serial command sequencer driving a combinational 8-bit ALU: collects opcode/A/B, holds operands,
// samples alu_f after EXEC_CYCLES, returns it over valid/ready. Define ALU_SEQ_FLAGS_EN to add result flags.
module alu_cmd_sequencer #(
   parameter int WIDTH       = 8,
   parameter int EXEC_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_s,
   output logic             alu_s2,
   input  logic [WIDTH-1:0] alu_f,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
`ifdef ALU_SEQ_FLAGS_EN
   output logic [1:0]       flags,
`endif
   input  logic             out_ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_A,
      S_GET_B,
      S_EXEC,
      S_RESP
   } state_e;

   localparam int               CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [1:0]         s_q, s_d;
   logic               s2_q, s2_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               valid_q, valid_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               accept;
`ifdef ALU_SEQ_FLAGS_EN
   logic [1:0]         flags_q, flags_d;
`endif

   // Ready depends on state alone so the producer never sees a combinational loop through in_valid.
   assign in_ready = (state_q == S_IDLE) || (state_q == S_GET_A) || (state_q == S_GET_B);
   assign accept   = in_valid && in_ready;

   // NOTE: every _d gets its hold value before the case, so no path leaves a signal unassigned (no latches).
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      s2_d    = s2_q;
      acc_d   = acc_q;
      res_d   = res_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
`ifdef ALU_SEQ_FLAGS_EN
      flags_d = flags_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               s_d  = in_data[1:0];
               s2_d = in_data[2];
               if (in_data[7]) begin
                  a_d     = acc_q;
                  state_d = S_GET_B;
               end else begin
                  state_d = S_GET_A;
               end
            end
         end
         S_GET_A: begin
            if (accept) begin
               a_d     = in_data;
               state_d = S_GET_B;
            end
         end
         S_GET_B: begin
            if (accept) begin
               b_d     = in_data;
               cnt_d   = CNT_LOAD;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               res_d   = alu_f;
               acc_d   = alu_f;
               valid_d = 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
               flags_d = {^alu_f, (alu_f == '0)};
`endif
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         s2_q    <= 1'b0;
         acc_q   <= '0;
         res_q   <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
`ifdef ALU_SEQ_FLAGS_EN
         flags_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         s2_q    <= s2_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
`ifdef ALU_SEQ_FLAGS_EN
         flags_q <= flags_d;
`endif
      end
   end

   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_s     = s_q;
   assign alu_s2    = s2_q;
   assign out_data  = res_q;
   assign out_valid = valid_q;
`ifdef ALU_SEQ_FLAGS_EN
   assign flags     = flags_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: directed scenarios plus randomized commands against a
// command-level reference model; a decoupled monitor compares every result the DUT presents.
module tb_alu_cmd_sequencer;

   localparam int EXEC = 3;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] s;
      logic       s2;
      logic [7:0] res;
      logic [1:0] flg;
      int         b_edge;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [1:0] alu_s;
   logic       alu_s2;
   logic [7:0] alu_f;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
`ifdef ALU_SEQ_FLAGS_EN
   logic [1:0] flags;
`endif

   exp_t       sb[$];
   exp_t       mon_e;
   logic [7:0] model_acc = 8'h00;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_pass = 0;
   bit         rdy_rand = 0;
   bit         rdy_val = 1;
   bit         prev_valid = 0;
   bit         just_popped = 0;

   alu_cmd_sequencer #(.WIDTH(8), .EXEC_CYCLES(EXEC)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_s    (alu_s),
      .alu_s2   (alu_s2),
      .alu_f    (alu_f),
      .out_data (out_data),
      .out_valid(out_valid),
`ifdef ALU_SEQ_FLAGS_EN
      .flags    (flags),
`endif
      .out_ready(out_ready)
   );

   // Behavioural ALU sitting behind the sequencer.
   assign alu_f = alu_s2 ? (alu_a & alu_b) : 8'(alu_a + alu_b);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Offers one byte; returns the index of the clock edge that accepted it.
   task automatic send_byte(input logic [7:0] b, input int gap, output int edge_n);
      bit ok = 0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      in_data  = b;
      in_valid = 1'b1;
      edge_n   = -1000;
      for (int w = 0; w < 200; w++) begin
         @(negedge clk);
         if (in_ready) begin
            edge_n = cyc + 1;
            @(posedge clk);
            ok = 1;
            break;
         end
      end
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (!ok) check("byte_accept_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic send_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                           input int gap);
      exp_t e;
      int   edge_n;
      e.a  = op[7] ? model_acc : a;
      e.b  = b;
      e.s  = op[1:0];
      e.s2 = op[2];
      send_byte(op, gap, edge_n);
      if (!op[7]) send_byte(a, gap, edge_n);
      send_byte(b, gap, edge_n);
      e.res    = e.s2 ? (e.a & e.b) : 8'((int'(e.a) + int'(e.b)) % 256);
      e.flg    = {($countones(e.res) % 2) == 1, e.res == 8'h00};
      e.b_edge = edge_n;
      model_acc = e.res;
      sb.push_back(e);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: operand stability during EXEC, result/latency/hold during RESP, no bypass after it.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid  = 0;
         just_popped = 0;
      end else begin
         if (just_popped) begin
            check("ready_after_result", 32'(in_ready), 32'd1);
            check("valid_after_result", 32'(out_valid), 32'd0);
            just_popped = 0;
         end else if (out_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_result", 32'(out_valid), 32'd0);
            end else begin
               mon_e = sb[0];
               if (!prev_valid) check("latency_edges", 32'(cyc - mon_e.b_edge), 32'(EXEC));
               check("out_data", 32'(out_data), 32'(mon_e.res));
`ifdef ALU_SEQ_FLAGS_EN
               check("flags", 32'(flags), 32'(mon_e.flg));
`endif
               check("in_ready_in_resp", 32'(in_ready), 32'd0);
               if (out_ready) begin
                  void'(sb.pop_front());
                  just_popped = 1;
               end
            end
         end else if (!in_ready) begin
            if (sb.size() == 0) begin
               check("busy_without_cmd", 32'(in_ready), 32'd1);
            end else begin
               mon_e = sb[0];
               check("exec_alu_a", 32'(alu_a), 32'(mon_e.a));
               check("exec_alu_b", 32'(alu_b), 32'(mon_e.b));
               check("exec_alu_s", 32'(alu_s), 32'(mon_e.s));
               check("exec_alu_s2", 32'(alu_s2), 32'(mon_e.s2));
            end
         end
         prev_valid = out_valid;
      end
   end

   initial begin
      int wv;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_alu_a", 32'(alu_a), 32'd0);
      check("rst_alu_b", 32'(alu_b), 32'd0);
      check("rst_alu_s", 32'(alu_s), 32'd0);
      check("rst_alu_s2", 32'(alu_s2), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Basic add, logic op, accumulate chain, zero result.
      send_cmd(8'h00, 8'h12, 8'h34, 0);
      wait_idle();
      send_cmd(8'h04, 8'hF0, 8'h3C, 0);
      wait_idle();
      send_cmd(8'h00, 8'h05, 8'h03, 0);
      wait_idle();
      send_cmd(8'h80, 8'h00, 8'h10, 0);
      wait_idle();
      send_cmd(8'h00, 8'hFF, 8'h01, 0);
      wait_idle();

      // Output back-pressure with a byte offered the whole time.
      rdy_val = 0;
      send_cmd(8'h00, 8'h12, 8'h34, 0);
      wv = 0;
      while (!out_valid && wv < 100) begin
         @(negedge clk);
         wv++;
      end
      check("bp_result_seen", 32'(out_valid), 32'd1);
      in_data  = 8'hA5;
      in_valid = 1'b1;
      repeat (5) @(negedge clk);
      in_valid = 1'b0;
      rdy_val  = 1;
      wait_idle();

      // Reset after the A byte: partial command and accumulator discarded.
      send_byte(8'h00, 0, wv);
      send_byte(8'h12, 0, wv);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_alu_a", 32'(alu_a), 32'd0);
      check("midrst_alu_b", 32'(alu_b), 32'd0);
      check("midrst_alu_s", 32'(alu_s), 32'd0);
      check("midrst_alu_s2", 32'(alu_s2), 32'd0);
      check("midrst_out_data", 32'(out_data), 32'd0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      model_acc = 8'h00;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_cmd(8'h80, 8'h00, 8'h07, 0);
      wait_idle();

      // Randomized commands with input gaps and random output back-pressure.
      rdy_rand = 1;
      for (int i = 0; i < 40; i++) begin
         send_cmd(8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 2));
         wait_idle();
      end
      rdy_rand = 0;
      rdy_val  = 1;
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
